// File: rtl/fixed_priority_arbiter.sv
// Registered fixed-priority arbiter: REQ[0] highest, one-cycle grant latency.
// Define FIXED_PRIORITY_ARBITER_LOCK_EN to hold the grant while its holder keeps requesting.
module fixed_priority_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         REQ,
   output logic [N-1:0]         GNT,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id
);

   localparam int IW = $clog2(N);

   logic [N-1:0]  gnt_q,   gnt_d;
   logic          valid_q, valid_d;
   logic [IW-1:0] id_q,    id_d;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_id;
   logic          pick_valid;

   // Descending scan so the lowest-index request is the last (winning) assignment.
   always_comb begin
      pick_gnt   = '0;
      pick_id    = '0;
      pick_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (REQ[i]) begin
            pick_gnt    = '0;
            pick_gnt[i] = 1'b1;
            pick_id     = IW'(i);
            pick_valid  = 1'b1;
         end
      end
   end

`ifdef FIXED_PRIORITY_ARBITER_LOCK_EN
   // The registered grant doubles as the lock: keep it while its holder still requests.
   always_comb begin
      gnt_d   = pick_gnt;
      id_d    = pick_id;
      valid_d = pick_valid;
      if (valid_q && ((REQ & gnt_q) != '0)) begin
         gnt_d   = gnt_q;
         id_d    = id_q;
         valid_d = 1'b1;
      end
   end
`else
   always_comb begin
      gnt_d   = pick_gnt;
      id_d    = pick_id;
      valid_d = pick_valid;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         id_q    <= id_d;
      end
   end

   assign GNT       = gnt_q;
   assign gnt_valid = valid_q;
   assign gnt_id    = id_q;

endmodule

// File: tb/tb_fixed_priority_arbiter.sv
// Directed and random checks of fixed_priority_arbiter against a queued reference model.
module tb_fixed_priority_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] REQ;
   logic [3:0] GNT;
   logic       gnt_valid;
   logic [1:0] gnt_id;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] sb[$];
   logic [3:0] model_q = 4'b0000;

   fixed_priority_arbiter #(.N(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .REQ       (REQ),
      .GNT       (GNT),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] prio(input logic [3:0] r);
      for (int i = 0; i < 4; i++)
         if (r[i]) return 4'(1 << i);
      return 4'b0000;
   endfunction

   function automatic logic [1:0] idx(input logic [3:0] g);
      for (int i = 0; i < 4; i++)
         if (g[i]) return 2'(i);
      return 2'd0;
   endfunction

   function automatic logic [3:0] model_next(input logic [3:0] r);
      logic [3:0] n;
      n = prio(r);
`ifdef FIXED_PRIORITY_ARBITER_LOCK_EN
      if ((model_q & r) != 4'b0000) n = model_q;
`endif
      model_q = n;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_outputs(input string tag, input logic [3:0] e);
      chk({tag, "_gnt"},    32'(GNT),       32'(e));
      chk({tag, "_valid"},  32'(gnt_valid), 32'(e != 4'b0000));
      chk({tag, "_id"},     32'(gnt_id),    32'(idx(e)));
      chk({tag, "_onehot"}, 32'($countones(GNT) <= 1), 32'(1));
      chk({tag, "_cons"},   32'((gnt_valid == |GNT) && (gnt_id == idx(GNT))), 32'(1));
   endtask

   task automatic step(input logic [3:0] r, input string tag);
      logic [3:0] e;
      @(negedge clk);
      REQ = r;
      sb.push_back(model_next(r));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_outputs(tag, e);
   endtask

   initial begin
      reset = 1'b0;
      REQ   = 4'b1111;

      // Reset held with all requests active.
      repeat (3) begin
         @(posedge clk);
         #1;
         chk_outputs("in_reset", 4'b0000);
      end

      @(negedge clk);
      reset = 1'b1;
      model_q = 4'b0000;
      step(4'b1111, "release");

      // Asynchronous reset between edges.
      step(4'b0100, "pre_async");
      #2;
      reset = 1'b0;
      #1;
      chk_outputs("async_rst", 4'b0000);
      @(negedge clk);
      reset = 1'b1;
      model_q = 4'b0000;

      step(4'b0001, "single0");
      step(4'b0010, "single1");
      step(4'b0100, "single2");
      step(4'b1000, "single3");
      step(4'b0000, "none");

      step(4'b1010, "prio_1010");
      step(4'b1100, "prio_1100");
      step(4'b1111, "prio_1111");
      step(4'b1000, "prio_1000");
      step(4'b0000, "idle");

      // Preemption without lock, hold with lock.
      step(4'b1000, "pre_a");
      step(4'b1000, "pre_b");
      step(4'b1001, "pre_hi");
      step(4'b1001, "pre_hi2");
      step(4'b0001, "pre_drop");
      step(4'b0011, "hold0");
      step(4'b0010, "drop0");

      for (int k = 0; k < 24; k++)
         step(4'($urandom_range(0, 15)), "rand");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fixed_priority_arbiter.md
Name: fixed_priority_arbiter

Overview:
- Registered fixed-priority arbiter for N requesters (default 4).
- Each clock, grants exactly one requester: the lowest-index active request. Grants nothing when no request is active.
- Sits in front of a shared resource (bus/port). Requesters hold their REQ bit high while they need access.

Parameters:
- N, 4, number of requesters. Sets the width of REQ and GNT. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 = in reset.
- REQ  input  N  request vector. Bit i high = requester i wants the resource.
- GNT  output  N  registered one-hot grant vector. Bit i high = requester i owns the resource this cycle.
- gnt_valid  output  1  registered. High when any GNT bit is set (equals OR-reduction of GNT).
- gnt_id  output  clog2(N)  registered binary index of the granted requester. 0 when gnt_valid is low.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset assertion (reset=0), any time including mid-operation: GNT=0, gnt_valid=0, gnt_id=0 immediately, independent of clk. Outputs stay 0 while reset is low.
- Reset release: first grant can appear at the first rising clk edge with reset=1.
- Priority is fixed: REQ[0] highest, REQ[N-1] lowest.
- At each rising edge (reset=1), base mode:
  - GNT <= one-hot of the lowest-index set bit of REQ.
  - REQ all zero -> GNT <= 0.
- Latency: one cycle. A REQ value sampled at edge k is reflected in GNT after edge k. No combinational path from REQ to any output.
- Base mode is preemptive: a higher-priority request arriving takes the grant at the next edge, even if a lower-priority grant is active.
- A requester dropping REQ loses its grant at the next edge.
- Invariants:
  - GNT is always one-hot or zero (never more than one bit set).
  - A GNT bit is only set if the corresponding REQ bit was set at the sampling edge.
  - gnt_id and gnt_valid are always consistent with GNT.
- No starvation protection: requester N-1 can be starved indefinitely. This is intended.
- REQ is synchronous to clk. X/Z on REQ is not supported and is not sanitized.

Optional Feature:
- Macro: FIXED_PRIORITY_ARBITER_LOCK_EN.
- Defined (non-preemptive lock):
  - While the current grant holder i keeps REQ[i]=1, GNT stays on i, even if higher-priority requests are active.
  - When REQ[i] drops, the next edge re-arbitrates with normal fixed priority over the current REQ.
  - Reset clears the lock.
- Undefined: purely preemptive behaviour as in Behaviour. No lock register is synthesized.

Test Plan:
- Reset: hold reset=0 with REQ=4'b1111 over several clk edges -> GNT=0000, gnt_valid=0, gnt_id=0. Release reset -> GNT=0001 after the next edge. Drop reset mid-grant between edges -> GNT=0000 immediately.
- Single requests: REQ=0001, 0010, 0100, 1000, each held one cycle -> GNT equals REQ one edge later; gnt_id=0,1,2,3 respectively. REQ=0000 -> GNT=0000, gnt_valid=0.
- Priority: REQ=1010 -> GNT=0010 (gnt_id=1). REQ=1100 -> GNT=0100. REQ=1111 -> GNT=0001. REQ=1000 -> GNT=1000.
- Preemption (macro off): REQ=1000 for 2 cycles (GNT=1000), then REQ=1001 -> GNT=0001 at the next edge.
- Lock (macro on): same sequence -> GNT stays 1000 while REQ[3]=1. Then REQ=0001 -> GNT=0001 at the next edge.
- Random: 20+ random REQ values, changing off the clock edge. Every cycle, check GNT against the reference priority function of REQ sampled at the prior edge. Check one-hot/zero and gnt_id/gnt_valid consistency every cycle.
